pixel_controller: RTL and testbench

- Display-scan controller for an 8-digit, common-anode, time-multiplexed 7-segment display in the memory-display path.
- Each tick of the 480 Hz scan clock advances to the next digit: drives exactly one anode enable low and outputs that digit's index on seg_sel.
- The downstream digit-data mux uses seg_sel to route the matching nibble to the segment decoder.
- Full 8-digit refresh rate = 60 Hz.

---
 rtl/pixel_controller.sv | 74 +++++++
 tb/tb_pixel_controller.sv | 107 ++++++++++
 2 files changed

// File: rtl/pixel_controller.sv
// Scan controller for an 8-digit common-anode 7-segment display: each scan tick
// enables the next digit (active-low anode) and reports its index on seg_sel.
module pixel_controller (
    input  logic       clk_480Hz,
    input  logic       reset,
    output logic       a7,
    output logic       a6,
    output logic       a5,
    output logic       a4,
    output logic       a3,
    output logic       a2,
    output logic       a1,
    output logic       a0,
    output logic [2:0] seg_sel
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  anodes_reg;
    logic [2:0]  seg_sel_reg;

    // Constant one-cold anode pattern for each digit position.
    logic [7:0]  anode_pattern [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pattern
            assign anode_pattern[gi] = ~(8'b1 << gi);
        end
    endgenerate

    always_comb begin
        state_next = S0;
        unique case (state_reg)
            S0:      state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = S3;
            S3:      state_next = S4;
            S4:      state_next = S5;
            S5:      state_next = S6;
            S6:      state_next = S7;
            S7:      state_next = S0;
            default: state_next = S0;
        endcase
    end

    // Outputs are registered from the next state so all anodes and seg_sel
    // switch together on the same edge, with no decode glitches between them.
    always_ff @(posedge clk_480Hz) begin
        if (!reset) begin
            state_reg   <= S0;
            anodes_reg  <= anode_pattern[0];
            seg_sel_reg <= 3'd0;
        end else begin
            state_reg   <= state_next;
            anodes_reg  <= anode_pattern[state_next];
            seg_sel_reg <= state_next;
        end
    end

    assign {a7, a6, a5, a4, a3, a2, a1, a0} = anodes_reg;
    assign seg_sel = seg_sel_reg;

endmodule

// File: tb/tb_pixel_controller.sv
// Self-checking bench for pixel_controller: directed scan/reset steps followed by
// randomized reset activity, compared against a digit-index reference model.
module tb_pixel_controller;

    logic       clk_480Hz = 1'b0;
    logic       reset = 1'b1;
    logic       a7, a6, a5, a4, a3, a2, a1, a0;
    logic [2:0] seg_sel;

    int total = 0;
    int bad   = 0;
    int model_digit = 0;

    pixel_controller dut (
        .clk_480Hz (clk_480Hz),
        .reset     (reset),
        .a7        (a7),
        .a6        (a6),
        .a5        (a5),
        .a4        (a4),
        .a3        (a3),
        .a2        (a2),
        .a1        (a1),
        .a0        (a0),
        .seg_sel   (seg_sel)
    );

    always #5 clk_480Hz = ~clk_480Hz;

    task automatic check(input string tag);
        logic [7:0] observed;
        logic [7:0] expected;
        int         low_count;
        int         low_index;
        observed  = {a7, a6, a5, a4, a3, a2, a1, a0};
        expected  = 8'hFF;
        expected[model_digit] = 1'b0;
        low_count = 0;
        low_index = -1;
        for (int k = 0; k < 8; k++) begin
            if (observed[k] === 1'b0) begin
                low_count++;
                low_index = k;
            end
        end
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s anodes observed=%b expected=%b", tag, observed, expected);
        end
        total++;
        assert (seg_sel === 3'(model_digit)) else begin
            bad++;
            $error("FAIL %s seg_sel observed=%0d expected=%0d", tag, seg_sel, model_digit);
        end
        total++;
        assert (low_count == 1 && low_index == int'(seg_sel)) else begin
            bad++;
            $error("FAIL %s onehot observed lows=%0d idx=%0d expected lows=1 idx=%0d",
                   tag, low_count, low_index, seg_sel);
        end
    endtask

    // One rising edge with the given reset level, then advance the model and check.
    task automatic tick(input logic rst, input string tag);
        reset = rst;
        @(posedge clk_480Hz);
        #1;
        if (!rst) model_digit = 0;
        else      model_digit = (model_digit + 1) % 8;
        check(tag);
    endtask

    initial begin
        // Reset held low for four edges.
        tick(1'b0, "reset_first");
        for (int i = 0; i < 3; i++) tick(1'b0, "reset_hold");

        // Walk S1..S7, wrap, then two full cycles.
        for (int i = 0; i < 7; i++) tick(1'b1, "walk");
        tick(1'b1, "wrap");
        for (int i = 0; i < 16; i++) tick(1'b1, "cycles");

        // Advance to S4, then reset mid-sequence.
        while (model_digit != 4) tick(1'b1, "to_s4");
        tick(1'b0, "mid_reset");
        tick(1'b1, "after_reset");

        // Reset pulse between edges must not change anything.
        reset = 1'b0;
        #2;
        check("async_glitch_low");
        reset = 1'b1;
        #2;
        check("async_glitch_high");
        tick(1'b1, "post_glitch");

        // Randomized reset activity.
        for (int i = 0; i < 60; i++) begin
            tick(($urandom_range(0, 7) != 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
